// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared types and constants for the memory access stage
package mem_access_pkg;

    localparam int WORD_W          = 32;
    localparam int REG_W           = 5;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Contents of the MEM/WB pipeline register.
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_W-1:0]  wn;
        logic [WORD_W-1:0] mem_data;
        logic [WORD_W-1:0] alu;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_register.sv
// rtl/mem_wb_register.sv - MEM/WB pipeline register with load and bubble controls
module mem_wb_register
    import mem_access_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    load_i,
    input  logic    bubble_i,
    input  mem_wb_t d_i,
    output mem_wb_t q_o
);

    mem_wb_t wb_q;

    // Bubble has priority over load; a bubble clears every field so nothing is written back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q <= '0;
        end else if (bubble_i) begin
            wb_q <= '0;
        end else if (load_i) begin
            wb_q <= d_i;
        end
    end

    assign q_o = wb_q;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage: data memory handshake, timeout and MEM/WB register
module mem_access_stage
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Branch,
    input  logic              zero,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic [REG_W-1:0]  rfile_wn,
    input  logic [WORD_W-1:0] alu_out,
    input  logic [WORD_W-1:0] RD2,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              PCSrc,
    output logic              stall,
    output logic              align_err,
    output logic              bus_err,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic [REG_W-1:0]  rfile_wn_out,
    output logic [WORD_W-1:0] mem_data_out,
    output logic [WORD_W-1:0] alu_out_out
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rw_q, rw_d;
    logic              m2r_q, m2r_d;
    logic [REG_W-1:0]  wn_q, wn_d;
    logic              align_err_q, align_err_d;
    logic              bus_err_q, bus_err_d;

    logic              mem_op;
    logic              aligned;
    logic              timeout_hit;
    logic              wb_load;
    logic              wb_bubble;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;

    assign mem_op      = MemRead | MemWrite;
    assign aligned     = (alu_out[1:0] == 2'b00);
    // cnt_q holds the number of ACCESS cycles already spent, so the TIMEOUT-th cycle sees TIMEOUT-1.
    assign timeout_hit = (cnt_q == LAST_CNT);

    // State, access counter, latched request and one-cycle error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rw_q        <= 1'b0;
            m2r_q       <= 1'b0;
            wn_q        <= '0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rw_q        <= rw_d;
            m2r_q       <= m2r_d;
            wn_q        <= wn_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state, stall and MEM/WB load/bubble selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rw_d        = rw_q;
        m2r_d       = m2r_q;
        wn_d        = wn_q;
        align_err_d = 1'b0;
        bus_err_d   = 1'b0;
        stall       = 1'b0;
        wb_load     = 1'b0;
        wb_bubble   = 1'b0;
        wb_d        = '0;

        case (state_q)
            IDLE: begin
                if (mem_op && aligned) begin
                    // Capture the request so upstream changes cannot disturb the bus.
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    addr_d    = alu_out;
                    wdata_d   = RD2;
                    we_d      = MemWrite;
                    rw_d      = RegWrite;
                    m2r_d     = MemtoReg;
                    wn_d      = rfile_wn;
                    cnt_d     = '0;
                    state_d   = ACCESS;
                end else if (mem_op) begin
                    // Misaligned: drop the access, flag it, let the pipeline move on.
                    align_err_d = 1'b1;
                    wb_bubble   = 1'b1;
                end else begin
                    wb_load         = 1'b1;
                    wb_d.reg_write  = RegWrite;
                    wb_d.mem_to_reg = MemtoReg;
                    wb_d.wn         = rfile_wn;
                    wb_d.mem_data   = '0;
                    wb_d.alu        = alu_out;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    // Ack wins even on the final allowed cycle.
                    wb_load         = 1'b1;
                    wb_d.reg_write  = rw_q;
                    wb_d.mem_to_reg = m2r_q;
                    wb_d.wn         = wn_q;
                    wb_d.mem_data   = we_q ? '0 : dmem_rdata;
                    wb_d.alu        = addr_q;
                    cnt_d           = '0;
                    state_d         = IDLE;
                end else if (timeout_hit) begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    bus_err_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_wb_register u_mem_wb (
        .clk      (clk),
        .reset    (reset),
        .load_i   (wb_load),
        .bubble_i (wb_bubble),
        .d_i      (wb_d),
        .q_o      (wb_q)
    );

    assign dmem_req     = (state_q == ACCESS);
    assign dmem_we      = dmem_req & we_q;
    assign dmem_addr    = dmem_req ? addr_q : '0;
    assign dmem_wdata   = dmem_req ? wdata_q : '0;
    assign PCSrc        = Branch & zero & ~stall;
    assign align_err    = align_err_q;
    assign bus_err      = bus_err_q;
    assign RegWrite_out = wb_q.reg_write;
    assign MemtoReg_out = wb_q.mem_to_reg;
    assign rfile_wn_out = wb_q.wn;
    assign mem_data_out = wb_q.mem_data;
    assign alu_out_out  = wb_q.alu;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    typedef struct {
        logic        rst, br, zr, mr, mw, rw, m2r, ack;
        logic [4:0]  wn;
        logic [31:0] alu, rd2, rdata;
    } in_t;

    typedef struct {
        logic        stall, pc, req, we, aerr, berr, rw, m2r, full;
        logic [31:0] addr, wdata, mem, alu;
        logic [4:0]  wn;
    } exp_t;

    logic        clk, reset;
    logic        Branch, zero, MemRead, MemWrite, RegWrite, MemtoReg;
    logic [4:0]  rfile_wn;
    logic [31:0] alu_out, RD2, dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        PCSrc, stall, align_err, bus_err;
    logic        RegWrite_out, MemtoReg_out;
    logic [4:0]  rfile_wn_out;
    logic [31:0] mem_data_out, alu_out_out;

    exp_t exp_q[$];
    exp_t me;
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .Branch       (Branch),
        .zero         (zero),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemtoReg     (MemtoReg),
        .rfile_wn     (rfile_wn),
        .alu_out      (alu_out),
        .RD2          (RD2),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .PCSrc        (PCSrc),
        .stall        (stall),
        .align_err    (align_err),
        .bus_err      (bus_err),
        .RegWrite_out (RegWrite_out),
        .MemtoReg_out (MemtoReg_out),
        .rfile_wn_out (rfile_wn_out),
        .mem_data_out (mem_data_out),
        .alu_out_out  (alu_out_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", n, cyc_n, act, req);
        end
    endfunction

    function automatic in_t nop();
        in_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic in_t ld(logic [4:0] wn, logic [31:0] a);
        in_t r;
        r = nop();
        r.mr = 1'b1; r.rw = 1'b1; r.m2r = 1'b1; r.wn = wn; r.alu = a;
        return r;
    endfunction

    function automatic exp_t ew(logic rw, logic m2r, logic [4:0] wn, logic [31:0] mem, logic [31:0] alu);
        exp_t r;
        r = '{default: '0};
        r.full = 1'b1; r.rw = rw; r.m2r = m2r; r.wn = wn; r.mem = mem; r.alu = alu;
        return r;
    endfunction

    function automatic exp_t ez();
        return ew(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endfunction

    function automatic exp_t eb();
        exp_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic exp_t eacc(logic [31:0] a, logic st);
        exp_t r;
        r = eb();
        r.req = 1'b1; r.addr = a; r.stall = st;
        return r;
    endfunction

    task automatic cyc(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        reset      = i.rst;
        Branch     = i.br;
        zero       = i.zr;
        MemRead    = i.mr;
        MemWrite   = i.mw;
        RegWrite   = i.rw;
        MemtoReg   = i.m2r;
        rfile_wn   = i.wn;
        alu_out    = i.alu;
        RD2        = i.rd2;
        dmem_ack   = i.ack;
        dmem_rdata = i.rdata;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the stage presents a full output snapshot; compare it against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            cyc_n++;
            chk("stall", 32'(stall), 32'(me.stall));
            chk("PCSrc", 32'(PCSrc), 32'(me.pc));
            chk("dmem_req", 32'(dmem_req), 32'(me.req));
            chk("align_err", 32'(align_err), 32'(me.aerr));
            chk("bus_err", 32'(bus_err), 32'(me.berr));
            chk("RegWrite_out", 32'(RegWrite_out), 32'(me.rw));
            chk("MemtoReg_out", 32'(MemtoReg_out), 32'(me.m2r));
            if (me.req) begin
                chk("dmem_we", 32'(dmem_we), 32'(me.we));
                chk("dmem_addr", dmem_addr, me.addr);
                if (me.we) chk("dmem_wdata", dmem_wdata, me.wdata);
            end
            if (me.full) begin
                chk("rfile_wn_out", 32'(rfile_wn_out), 32'(me.wn));
                chk("mem_data_out", mem_data_out, me.mem);
                chk("alu_out_out", alu_out_out, me.alu);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc_n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_t  i;
        exp_t e;
        reset = 1'b1; Branch = 1'b0; zero = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        RegWrite = 1'b0; MemtoReg = 1'b0; rfile_wn = '0; alu_out = '0; RD2 = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        // Reset state, then an ALU op with 1-cycle latency and a taken branch.
        i = nop(); i.rst = 1'b1; cyc(i, ez());
        i = nop(); i.rw = 1'b1; i.wn = 5'd5; i.alu = 32'h10; cyc(i, ez());
        i = nop(); i.br = 1'b1; i.zr = 1'b1; e = ew(1'b1, 1'b0, 5'd5, 32'd0, 32'h10); e.pc = 1'b1; cyc(i, e);

        // Load at 0x100, ack on the 4th ACCESS cycle; branch masked while stalled.
        i = ld(5'd7, 32'h100); i.br = 1'b1; i.zr = 1'b1; e = ez(); e.stall = 1'b1; cyc(i, e);
        for (int k = 0; k < 3; k++) cyc(nop(), eacc(32'h100, 1'b1));
        i = nop(); i.ack = 1'b1; i.rdata = 32'hDEADBEEF; cyc(i, eacc(32'h100, 1'b0));
        cyc(nop(), ew(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 32'h100));

        // Store 0x55 to 0x20, ack on the first ACCESS cycle.
        i = nop(); i.mw = 1'b1; i.wn = 5'd3; i.alu = 32'h20; i.rd2 = 32'h55; e = ez(); e.stall = 1'b1; cyc(i, e);
        i = nop(); i.ack = 1'b1; i.rdata = 32'h12345678; e = eacc(32'h20, 1'b0); e.we = 1'b1; e.wdata = 32'h55; cyc(i, e);
        cyc(nop(), ew(1'b0, 1'b0, 5'd3, 32'd0, 32'h20));

        // Load with no ack: abort after 16 ACCESS cycles.
        i = ld(5'd9, 32'h40); e = ez(); e.stall = 1'b1; cyc(i, e);
        for (int k = 0; k < 16; k++) cyc(nop(), eacc(32'h40, 1'b1));
        e = eb(); e.berr = 1'b1; cyc(nop(), e);
        cyc(nop(), ez());

        // Load with ack exactly on ACCESS cycle 16: completes, no bus error.
        i = ld(5'd10, 32'h44); e = ez(); e.stall = 1'b1; cyc(i, e);
        for (int k = 0; k < 15; k++) cyc(nop(), eacc(32'h44, 1'b1));
        i = nop(); i.ack = 1'b1; i.rdata = 32'hCAFEF00D; cyc(i, eacc(32'h44, 1'b0));
        cyc(nop(), ew(1'b1, 1'b1, 5'd10, 32'hCAFEF00D, 32'h44));
        cyc(nop(), ez());

        // Misaligned load: no request, no stall, one-cycle align_err with a bubble.
        cyc(ld(5'd4, 32'h102), ez());
        e = eb(); e.aerr = 1'b1; cyc(nop(), e);
        cyc(nop(), ez());

        // Reset in the middle of an access, then normal operation resumes.
        i = ld(5'd2, 32'h80); e = ez(); e.stall = 1'b1; cyc(i, e);
        cyc(nop(), eacc(32'h80, 1'b1));
        i = nop(); i.rst = 1'b1; cyc(i, ez());
        i = nop(); i.rw = 1'b1; i.wn = 5'd6; i.alu = 32'h33; cyc(i, ez());
        i = nop(); i.br = 1'b1; i.zr = 1'b1; e = ew(1'b1, 1'b0, 5'd6, 32'd0, 32'h33); e.pc = 1'b1; cyc(i, e);
        cyc(nop(), ez());

        @(posedge clk);
        #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
